// File: rtl/decode_cycle.sv
// Decode stage: instruction decoder, 32x32 register file with write-through
// bypass, and the decode/execute pipeline register.
module decode_cycle (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RAW   = 5;
  localparam int unsigned NREGS = 32;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic           funct7_b5;
  logic [RAW-1:0] rs1, rs2, rd;

  assign opcode    = InstrD[6:0];
  assign funct3    = InstrD[14:12];
  assign funct7_b5 = InstrD[30];
  assign rs1       = InstrD[19:15];
  assign rs2       = InstrD[24:20];
  assign rd        = InstrD[11:7];

  logic            reg_write, mem_write, jump, branch, alu_src;
  logic [1:0]      result_src;
  logic [2:0]      alu_ctrl;
  logic [XLEN-1:0] imm_ext;
  logic            fn_valid;
  logic [2:0]      fn_ctrl;

  // ALU operation for R-type / I-ALU from funct fields; unlisted funct3 is invalid
  always_comb begin
    fn_valid = 1'b1;
    fn_ctrl  = ALU_ADD;
    case (funct3)
      3'b000:  fn_ctrl = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b111:  fn_ctrl = ALU_AND;
      3'b110:  fn_ctrl = ALU_OR;
      3'b010:  fn_ctrl = ALU_SLT;
      default: fn_valid = 1'b0;
    endcase
  end

  // Main decoder and immediate generator; anything unrecognised is a NOP
  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    result_src = 2'b00;
    alu_ctrl   = ALU_ADD;
    imm_ext    = '0;
    case (opcode)
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
        imm_ext    = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_ext   = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_R: begin
        if (fn_valid) begin
          reg_write = 1'b1;
          alu_ctrl  = fn_ctrl;
        end
      end
      OP_IALU: begin
        imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
        if (fn_valid) begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_ctrl  = fn_ctrl;
        end
      end
      OP_BEQ: begin
        branch   = 1'b1;
        alu_ctrl = ALU_SUB;
        imm_ext  = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        result_src = 2'b10;
        imm_ext    = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wr_en;
  logic [XLEN-1:0] rd1, rd2;

  assign wr_en = RegWriteW && (RdW != '0);

  // Register file next state: single writeback port, x0 never written
  always_comb begin
    for (int i = 0; i < int'(NREGS); i++) regs_d[i] = regs_q[i];
    if (wr_en) regs_d[RdW] = ResultW;
  end

  // Register file storage, cleared asynchronously by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= regs_d[i];
    end
  end

  // Read ports: x0 reads zero, same-cycle writeback is forwarded
  always_comb begin
    rd1 = regs_q[rs1];
    rd2 = regs_q[rs2];
    if (wr_en && RdW == rs1) rd1 = ResultW;
    if (wr_en && RdW == rs2) rd2 = ResultW;
    if (rs1 == '0) rd1 = '0;
    if (rs2 == '0) rd2 = '0;
  end

  logic [9:0]      ctrl_d, ctrl_q;
  logic [3*RAW-1:0] idx_d, idx_q;
  logic [XLEN-1:0] rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
  logic [XLEN-1:0] pc_d, pc_q, pc4_d, pc4_q;

  // Execute register next state: flush zeroes control and register indices
  always_comb begin
    ctrl_d = {reg_write, mem_write, jump, branch, alu_src, result_src, alu_ctrl};
    idx_d  = {rs1, rs2, rd};
    rd1_d  = rd1;
    rd2_d  = rd2;
    imm_d  = imm_ext;
    pc_d   = PCD;
    pc4_d  = PCPlus4D;
    if (FlushE) begin
      ctrl_d = '0;
      idx_d  = '0;
    end
  end

  // Execute register storage, cleared asynchronously by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
      idx_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      pc4_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      idx_q  <= idx_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      pc_q   <= pc_d;
      pc4_q  <= pc4_d;
    end
  end

  assign {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE} = ctrl_q;
  assign {Rs1E, Rs2E, RdE} = idx_q;
  assign RD1E     = rd1_q;
  assign RD2E     = rd2_q;
  assign ImmExtE  = imm_q;
  assign PCE      = pc_q;
  assign PCPlus4E = pc4_q;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed scenarios plus random
// instructions compared against a behavioural model of the decode stage.
module tb_decode_cycle;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RdW;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_rf [32];

  decode_cycle dut (
    .clock(clock), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ctrl_vec();
    return {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE};
  endfunction

  // Reference control word {RegWrite,MemWrite,Jump,Branch,ALUSrc,ResultSrc,ALUControl}
  function automatic logic [9:0] ref_ctrl(input logic [31:0] i);
    logic [2:0] f3;
    logic [2:0] op;
    bit         ok;
    f3 = i[14:12];
    ok = 1'b1;
    op = 3'b000;
    if (f3 == 3'b000) op = (i[6:0] == 7'b0110011 && i[30]) ? 3'b001 : 3'b000;
    else if (f3 == 3'b111) op = 3'b010;
    else if (f3 == 3'b110) op = 3'b011;
    else if (f3 == 3'b010) op = 3'b101;
    else ok = 1'b0;
    if (i[6:0] == 7'b0000011) return 10'b1_0_0_0_1_01_000;
    if (i[6:0] == 7'b0100011) return 10'b0_1_0_0_1_00_000;
    if (i[6:0] == 7'b0110011) return ok ? {7'b1_0_0_0_0_00, op} : 10'd0;
    if (i[6:0] == 7'b0010011) return ok ? {7'b1_0_0_0_1_00, op} : 10'd0;
    if (i[6:0] == 7'b1100011) return 10'b0_0_0_1_0_00_001;
    if (i[6:0] == 7'b1101111) return 10'b1_0_1_0_0_10_000;
    return 10'd0;
  endfunction

  // Reference immediate via signed integer arithmetic; has_imm=0 for formats without one
  function automatic logic [31:0] ref_imm(input logic [31:0] i, output bit has_imm);
    int v;
    logic [11:0] f12;
    logic [19:0] f20;
    has_imm = 1'b1;
    v = 0;
    case (i[6:0])
      7'b0000011, 7'b0010011: begin
        f12 = i[31:20];
        v = int'(f12); if (v >= 2048) v -= 4096;
      end
      7'b0100011: begin
        f12 = {i[31:25], i[11:7]};
        v = int'(f12); if (v >= 2048) v -= 4096;
      end
      7'b1100011: begin
        f12 = {i[31], i[7], i[30:25], i[11:8]};
        v = int'(f12); if (v >= 2048) v -= 4096;
        v = v * 2;
      end
      7'b1101111: begin
        f20 = {i[31], i[19:12], i[20], i[30:21]};
        v = int'(f20); if (v >= 524288) v -= 1048576;
        v = v * 2;
      end
      default: has_imm = 1'b0;
    endcase
    return v;
  endfunction

  // One pipeline step: drive decode/writeback inputs, clock, compare against model
  task automatic step(input logic [31:0] instr, input logic rw, input logic [4:0] rd,
                      input logic [31:0] res, input logic flush);
    logic [31:0] pc, e1, e2, eimm;
    bit          has_imm;
    pc = $urandom() & 32'hFFFF_FFFC;
    InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = rw; RdW = rd; ResultW = res; FlushE = flush;
    @(posedge clock);
    #1;
    // Write-then-read gives the forwarded value the stage must see
    if (rw && rd != 5'd0) model_rf[rd] = res;
    e1 = model_rf[instr[19:15]];
    e2 = model_rf[instr[24:20]];
    eimm = ref_imm(instr, has_imm);
    if (flush) begin
      chk("flush_ctrl", 32'(ctrl_vec()), 32'd0);
      chk("flush_idx", {17'd0, Rs1E, Rs2E, RdE}, 32'd0);
    end else begin
      chk("ctrl", 32'(ctrl_vec()), 32'(ref_ctrl(instr)));
      chk("idx", {17'd0, Rs1E, Rs2E, RdE}, {17'd0, instr[19:15], instr[24:20], instr[11:7]});
      chk("rd1", RD1E, e1);
      chk("rd2", RD2E, e2);
      chk("pc", PCE, pc);
      chk("pc4", PCPlus4E, pc + 32'd4);
      if (has_imm) chk("imm", ImmExtE, eimm);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 32'(ctrl_vec()), 32'd0);
    chk({tag, "_idx"}, {17'd0, Rs1E, Rs2E, RdE}, 32'd0);
    chk({tag, "_rd1"}, RD1E, 32'd0);
    chk({tag, "_rd2"}, RD2E, 32'd0);
    chk({tag, "_imm"}, ImmExtE, 32'd0);
    chk({tag, "_pc"}, PCE, 32'd0);
    chk({tag, "_pc4"}, PCPlus4E, 32'd0);
  endtask

  logic [6:0] ops [8];
  logic [31:0] r, ins;
  int          k;

  initial begin
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b0010011;
    ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1111111; ops[7] = 7'b0000000;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;

    // Reset asserted with a writeback and an instruction pending: nothing may change
    reset = 1'b1;
    InstrD = 32'h00528333; PCD = 32'h100; PCPlus4D = 32'h104;
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEAD_BEEF; FlushE = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset_clk");
    #4;
    reset = 1'b0;

    // After reset every register reads zero
    step(32'h00528333, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("post_reset_x5", RD1E, 32'd0);

    // x5 = 0xAA, then add x6,x5,x5
    step(32'h00000013, 1'b1, 5'd5, 32'h0000_00AA, 1'b0);
    step(32'h00528333, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("add_rd1", RD1E, 32'hAA);
    chk("add_rd2", RD2E, 32'hAA);
    chk("add_rw", 32'(RegWriteE), 32'd1);
    chk("add_alu", 32'(ALUControlE), 32'd0);
    chk("add_rd", 32'(RdE), 32'd6);

    // lw x6,-4(x9)
    step(32'hFFC4A303, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("lw_imm", ImmExtE, 32'hFFFF_FFFC);
    chk("lw_rsrc", 32'(ResultSrcE), 32'd1);
    chk("lw_alusrc", 32'(ALUSrcE), 32'd1);

    // Same-cycle bypass of x7
    step(32'h00038333, 1'b1, 5'd7, 32'h0000_1234, 1'b0);
    chk("bypass_rd1", RD1E, 32'h1234);

    // Write to x0 is dropped, x0 reads zero
    step(32'h00000333, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    chk("x0_same", RD1E, 32'd0);
    step(32'h00000333, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("x0_after", RD1E, 32'd0);

    // Flush with jal in decode; writeback during flush still lands
    step(32'h008000EF, 1'b1, 5'd9, 32'h0BAD_F00D, 1'b1);
    chk("flush_jump", 32'(JumpE), 32'd0);
    chk("flush_rw", 32'(RegWriteE), 32'd0);
    step(32'h00048333, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("flush_wr_kept", RD1E, 32'h0BAD_F00D);

    // Unknown opcode and unlisted funct3 decode to NOP
    step(32'h0000007F, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("unk_ctrl", 32'(ctrl_vec()), 32'd0);
    step(32'h0052_9333, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("sll_nop", 32'(ctrl_vec()), 32'd0);

    // Random stream with a mid-stream asynchronous reset
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      k = int'($urandom_range(0, 7));
      ins = {r[31:7], ops[k]};
      if (k == 7) ins = r;
      step(ins, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(),
           ($urandom_range(0, 9) == 0));
      if (n == 200) begin
        reset = 1'b1;
        #2;
        chk_all_zero("mid_reset");
        #2;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 The block SHALL have no parameters; the register file is fixed at 32 x 32 bits.
REQ-002 Port: clock  input  1  pipeline clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous, active-high.
REQ-004 Port: InstrD  input  32  instruction from the fetch/decode pipeline register.
REQ-005 Port: PCD, PCPlus4D  input  32 each  PC and PC+4 of InstrD.
REQ-006 Port: RegWriteW  input  1  writeback enable.
REQ-007 Port: RdW  input  5  writeback destination register.
REQ-008 Port: ResultW  input  32  writeback data.
REQ-009 Port: FlushE  input  1  synchronous bubble insert into the execute register.
REQ-010 Port: RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  output  1 each  registered control signals.
REQ-011 Port: ResultSrcE  output  2  result select: 00 ALU, 01 memory, 10 PC+4.
REQ-012 Port: ALUControlE  output  3  ALU operation code.
REQ-013 Port: RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  32 each  registered operands and PCs.
REQ-014 Port: Rs1E, Rs2E, RdE  output  5 each  registered register indices for hazard logic.

Function
REQ-015 Decode SHALL be combinational from InstrD; all outputs SHALL appear exactly one clock after InstrD is presented, with a latency of 1.
REQ-016 Opcode 0000011 (lw) SHALL produce RegWrite=1, ALUSrc=1, ResultSrc=01, ALUControl=000, and an I-type immediate.
REQ-017 Opcode 0100011 (sw) SHALL produce MemWrite=1, ALUSrc=1, ALUControl=000, and an S-type immediate.
REQ-018 Opcode 0110011 (R-type) SHALL produce RegWrite=1 and ALUSrc=0.
REQ-019 Opcode 0010011 (I-ALU) SHALL produce RegWrite=1 and ALUSrc=1, with an I-type immediate.
REQ-020 Opcode 1100011 (beq) SHALL produce Branch=1, ALUSrc=0, ALUControl=001, and a B-type immediate.
REQ-021 Opcode 1101111 (jal) SHALL produce RegWrite=1, Jump=1, ResultSrc=10, and a J-type immediate.
REQ-022 ALUControl for R-type and I-ALU SHALL be set from funct3 and funct7:
- funct3 000 → add (000); R-type with funct7[5]=1 → sub (001).
- funct3 111 → and (010).
- funct3 110 → or (011).
- funct3 010 → slt (101).
REQ-023 Any unlisted opcode or funct combination SHALL decode to all-zero control, i.e. behave as a NOP with no writes.
REQ-024 Immediates SHALL be sign-extended from InstrD[31]; B-type and J-type immediates SHALL have bit 0 = 0.
REQ-025 Rs1 = InstrD[19:15], Rs2 = InstrD[24:20], Rd = InstrD[11:7], regardless of instruction format.
REQ-026 The register file SHALL write ResultW into RdW on the rising clock edge when RegWriteW=1 and RdW≠0.
REQ-027 Register x0 SHALL always read 0, and writes to x0 SHALL be ignored.
REQ-028 Read bypass: when RegWriteW=1, RdW≠0 and RdW equals Rs1 (or Rs2), RD1 (or RD2) SHALL return ResultW in the same cycle.
REQ-029 FlushE=1 at a rising edge SHALL load zero into all control outputs (RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE) and into RdE, Rs1E and Rs2E; data outputs are don't-care.
REQ-030 A register-file write in the same cycle as FlushE SHALL still occur.

Reset
REQ-031 reset=1 SHALL immediately clear every execute-register output to 0, independent of clock.
REQ-032 reset=1 SHALL immediately clear all 32 registers to 0, independent of clock.
REQ-033 Reset SHALL override FlushE and RegWriteW.
REQ-034 Deassertion of reset mid-stream SHALL yield correct decode of the InstrD present at the next rising edge.

Verification
REQ-035 Scenario: reset pulse, then any instruction → every output is 0 during reset; RD1E/RD2E read 0 for any register afterwards.
REQ-036 Scenario: write x5=0x0000_00AA via writeback, then InstrD=0x00528333 (add x6,x5,x5) → after one clock:
- RD1E=RD2E=0xAA, RegWriteE=1, ALUControlE=000, RdE=6.
REQ-037 Scenario: InstrD=0xFFC4A303 (lw x6,-4(x9)) → ImmExtE=0xFFFF_FFFC, ResultSrcE=01, ALUSrcE=1.
REQ-038 Scenario: RegWriteW=1, RdW=7, ResultW=0x1234 while InstrD reads x7 → RD1E=0x1234 on the next edge (bypass).
REQ-039 Scenario: RegWriteW=1, RdW=0, ResultW=0xFFFF_FFFF, then read x0 → RD1E=0.
REQ-040 Scenario: FlushE=1 with a jal in decode → JumpE=0 and RegWriteE=0 on the next edge.
REQ-041 Scenario: unknown opcode 0x0000007F → all control outputs are 0.
